// File: rtl/pool_pkg.sv
// Shared types for the 2x2 pooling window feeder.
//   pixel_t        : signed pixel word
//   feeder_state_e : handshake FSM states {FILL, REQ, REL, OUT}
//   window_t       : one 2x2 window, row-major (w00 w01 / w10 w11)
//   last_even_idx  : index of the last row/column that still completes a
//                    window (trailing odd row/column is dropped)
package pool_pkg;

  localparam int POOL_DATA_W = 16;

  typedef logic signed [POOL_DATA_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    FILL,
    REQ,
    REL,
    OUT
  } feeder_state_e;

  typedef struct packed {
    pixel_t w00;
    pixel_t w01;
    pixel_t w10;
    pixel_t w11;
  } window_t;

  function automatic int last_even_idx(input int n);
    return (n / 2) * 2 - 1;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Single-row line buffer for the window feeder.
// Holds one even row of pixels so the following odd row can pair with it.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_wr_en        : write i_wr_data at column i_wr_col
//   i_rd_col       : current column c
//   o_rd_prev      : buf[c-1]
//   o_rd_cur       : buf[c]
module pool_line_buffer
  import pool_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int COL_W = $clog2(IMG_W)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [COL_W-1:0] i_wr_col,
  input  pixel_t           i_wr_data,
  input  logic [COL_W-1:0] i_rd_col,
  output pixel_t           o_rd_prev,
  output pixel_t           o_rd_cur
);

  pixel_t           r_lineBuf [IMG_W];
  logic [COL_W-1:0] w_prevCol;

  // Column 0 never closes a window, so its "previous" read is clamped to
  // stay inside the array instead of wrapping.
  assign w_prevCol = (i_rd_col == '0) ? '0 : i_rd_col - COL_W'(1);
  assign o_rd_prev = r_lineBuf[w_prevCol];
  assign o_rd_cur  = r_lineBuf[i_rd_col];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < IMG_W; i++) r_lineBuf[i] <= '0;
    end else if (i_wr_en) begin
      r_lineBuf[i_wr_col] <= i_wr_data;
    end
  end

endmodule

// File: rtl/pool_window_feeder.sv
// Initiator side of the 2x2 pooling handshake.
// Accepts a raster-order pixel stream, forms non-overlapping stride-2 2x2
// windows, runs a four-phase start/finish handshake with the pooling unit
// and emits each pooled pixel on a valid/ready stream.
// Optional feature macro: POOL_FEEDER_TIMEOUT_EN enables a finish watchdog
// that raises sticky o_pool_err; without it o_pool_err is tied 0.
// Ports:
//   i_clk, i_rst_n                 : clock, asynchronous active-low reset
//   i_in_valid/o_in_ready/i_in_pixel : input pixel stream
//   o_pool_start, o_pool_w00..w11  : request and window to the pooling unit
//   i_pool_finish, i_pool_pixel    : completion and result from the unit
//   o_out_valid/i_out_ready/o_out_pixel/o_out_last : pooled pixel stream
//   o_pool_err                     : sticky watchdog error
module pool_window_feeder
  import pool_pkg::*;
#(
  parameter int IMG_W          = 28,
  parameter int IMG_H          = 28,
  parameter int DATA_W         = POOL_DATA_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_pixel,
  output logic              o_pool_start,
  output logic [DATA_W-1:0] o_pool_w00,
  output logic [DATA_W-1:0] o_pool_w01,
  output logic [DATA_W-1:0] o_pool_w10,
  output logic [DATA_W-1:0] o_pool_w11,
  input  logic              i_pool_finish,
  input  logic [DATA_W-1:0] i_pool_pixel,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_pixel,
  output logic              o_out_last,
  output logic              o_pool_err
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] LAST_COL     = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW     = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] LAST_WIN_COL = COL_W'(last_even_idx(IMG_W));
  localparam logic [ROW_W-1:0] LAST_WIN_ROW = ROW_W'(last_even_idx(IMG_H));

  feeder_state_e    r_state;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  pixel_t           r_prevPix;
  window_t          r_win;
  logic             r_winLast;
  logic             r_poolStart;
  logic             r_outValid;
  logic             r_outLast;
  pixel_t           r_outPixel;

  logic   w_inReady;
  logic   w_accept;
  logic   w_bufWr;
  logic   w_winDone;
  pixel_t w_bufPrev;
  pixel_t w_bufCur;

  // Ready is gated by reset so it reads 0 while reset is held and rises
  // as soon as the FSM sits in FILL after release.
  assign w_inReady = (r_state == FILL) && i_rst_n;
  assign w_accept  = i_in_valid && w_inReady;
  assign w_bufWr   = w_accept && !r_row[0];
  assign w_winDone = w_accept && r_row[0] && r_col[0];

  pool_line_buffer #(
    .IMG_W (IMG_W),
    .COL_W (COL_W)
  ) u_lineBuf (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (w_bufWr),
    .i_wr_col  (r_col),
    .i_wr_data (pixel_t'(i_in_pixel)),
    .i_rd_col  (r_col),
    .o_rd_prev (w_bufPrev),
    .o_rd_cur  (w_bufCur)
  );

`ifdef POOL_FEEDER_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_toCnt;
  logic            r_poolErr;
`else
  // Without the watchdog the limit has no effect; it is only range-checked.
  if (TIMEOUT_CYCLES < 1) begin : g_badTimeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
`endif

  // Raster counters, window capture and the four-phase handshake FSM.
  // The watchdog (when built in) shares the REQ/REL wait and forces the
  // FSM to OUT so the stream never stalls on a dead pooling unit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= FILL;
      r_col       <= '0;
      r_row       <= '0;
      r_prevPix   <= '0;
      r_win       <= '0;
      r_winLast   <= 1'b0;
      r_poolStart <= 1'b0;
      r_outValid  <= 1'b0;
      r_outLast   <= 1'b0;
      r_outPixel  <= '0;
`ifdef POOL_FEEDER_TIMEOUT_EN
      r_toCnt     <= '0;
      r_poolErr   <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_prevPix <= pixel_t'(i_in_pixel);
        if (r_col == LAST_COL) begin
          r_col <= '0;
          r_row <= (r_row == LAST_ROW) ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end

      case (r_state)
        FILL: begin
          if (w_winDone) begin
            r_win       <= '{w00: w_bufPrev, w01: w_bufCur,
                             w10: r_prevPix, w11: pixel_t'(i_in_pixel)};
            r_winLast   <= (r_row == LAST_WIN_ROW) && (r_col == LAST_WIN_COL);
            r_poolStart <= 1'b1;
            r_state     <= REQ;
`ifdef POOL_FEEDER_TIMEOUT_EN
            r_toCnt     <= '0;
`endif
          end
        end
        REQ: begin
          if (i_pool_finish) begin
            r_outPixel  <= pixel_t'(i_pool_pixel);
            r_poolStart <= 1'b0;
            r_state     <= REL;
          end
`ifdef POOL_FEEDER_TIMEOUT_EN
          else if (r_toCnt == TO_LAST) begin
            r_poolErr   <= 1'b1;
            r_poolStart <= 1'b0;
            r_outPixel  <= '0;
            r_outValid  <= 1'b1;
            r_outLast   <= r_winLast;
            r_state     <= OUT;
          end else begin
            r_toCnt <= r_toCnt + TO_W'(1);
          end
`endif
        end
        REL: begin
          if (!i_pool_finish) begin
            r_outValid <= 1'b1;
            r_outLast  <= r_winLast;
            r_state    <= OUT;
          end
`ifdef POOL_FEEDER_TIMEOUT_EN
          else if (r_toCnt == TO_LAST) begin
            r_poolErr  <= 1'b1;
            r_outValid <= 1'b1;
            r_outLast  <= r_winLast;
            r_state    <= OUT;
          end else begin
            r_toCnt <= r_toCnt + TO_W'(1);
          end
`endif
        end
        OUT: begin
          if (i_out_ready) begin
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
            r_state    <= FILL;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign o_in_ready   = w_inReady;
  assign o_pool_start = r_poolStart;
  assign o_pool_w00   = r_win.w00;
  assign o_pool_w01   = r_win.w01;
  assign o_pool_w10   = r_win.w10;
  assign o_pool_w11   = r_win.w11;
  assign o_out_valid  = r_outValid;
  assign o_out_pixel  = r_outPixel;
  assign o_out_last   = r_outLast;
`ifdef POOL_FEEDER_TIMEOUT_EN
  assign o_pool_err   = r_poolErr;
`else
  assign o_pool_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pool_window_feeder.sv
// Directed testbench for pool_window_feeder.
// dut4 runs a 4x4 frame against a pooler model with adjustable finish
// latency; dut5 runs a 5x5 frame against an ideal combinational pooler.
// The pooler models return the truncated average of the window, so every
// expected output below is hand-computed from the input pixel values.
module tb_pool_window_feeder;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // 4x4 instance signals
  logic inValid4, inReady4, poolStart4, poolFinish4, outValid4, outReady4, outLast4, poolErr4;
  logic signed [DW-1:0] inPixel4, w00_4, w01_4, w10_4, w11_4, poolPixel4, outPixel4;

  // 5x5 instance signals
  logic inValid5, inReady5, poolStart5, poolFinish5, outValid5, outReady5, outLast5, poolErr5;
  logic signed [DW-1:0] inPixel5, w00_5, w01_5, w10_5, w11_5, poolPixel5, outPixel5;

  pool_window_feeder #(
    .IMG_W (4), .IMG_H (4), .DATA_W (DW), .TIMEOUT_CYCLES (8)
  ) dut4 (
    .i_clk (clk), .i_rst_n (rst_n),
    .i_in_valid (inValid4), .o_in_ready (inReady4), .i_in_pixel (inPixel4),
    .o_pool_start (poolStart4),
    .o_pool_w00 (w00_4), .o_pool_w01 (w01_4), .o_pool_w10 (w10_4), .o_pool_w11 (w11_4),
    .i_pool_finish (poolFinish4), .i_pool_pixel (poolPixel4),
    .o_out_valid (outValid4), .i_out_ready (outReady4), .o_out_pixel (outPixel4),
    .o_out_last (outLast4), .o_pool_err (poolErr4)
  );

  pool_window_feeder #(
    .IMG_W (5), .IMG_H (5), .DATA_W (DW), .TIMEOUT_CYCLES (255)
  ) dut5 (
    .i_clk (clk), .i_rst_n (rst_n),
    .i_in_valid (inValid5), .o_in_ready (inReady5), .i_in_pixel (inPixel5),
    .o_pool_start (poolStart5),
    .o_pool_w00 (w00_5), .o_pool_w01 (w01_5), .o_pool_w10 (w10_5), .o_pool_w11 (w11_5),
    .i_pool_finish (poolFinish5), .i_pool_pixel (poolPixel5),
    .o_out_valid (outValid5), .i_out_ready (outReady5), .o_out_pixel (outPixel5),
    .o_out_last (outLast5), .o_pool_err (poolErr5)
  );

  // Pooler model for dut4: poolDelay4 == 0 behaves combinationally,
  // otherwise finish rises poolDelay4 edges after start and drops one
  // edge after start falls.
  int   poolDelay4 = 0;
  int   startCnt4 = 0;
  logic finishReg4 = 1'b0;
  always @(posedge clk) begin
    if (!poolStart4) begin
      startCnt4  <= 0;
      finishReg4 <= 1'b0;
    end else begin
      startCnt4 <= startCnt4 + 1;
      if (startCnt4 + 1 >= poolDelay4) finishReg4 <= 1'b1;
    end
  end
  assign poolFinish4 = (poolDelay4 == 0) ? poolStart4 : finishReg4;
  assign poolPixel4  = DW'((int'(w00_4) + int'(w01_4) + int'(w10_4) + int'(w11_4)) / 4);

  assign poolFinish5 = poolStart5;
  assign poolPixel5  = DW'((int'(w00_5) + int'(w01_5) + int'(w10_5) + int'(w11_5)) / 4);
  assign outReady5   = 1'b1;

  // Output / window monitors, sampled on the falling edge.
  int          outQ4[$];
  bit          lastQ4[$];
  int          outQ5[$];
  bit          lastQ5[$];
  logic [63:0] winQ4[$];
  logic        prevStart4 = 1'b0;
  logic        prevFinish4 = 1'b0;
  int          startOverFinish4 = 0;
  always @(negedge clk) begin
    if (outValid4 && outReady4) begin
      outQ4.push_back(int'(outPixel4));
      lastQ4.push_back(outLast4);
    end
    if (outValid5 && outReady5) begin
      outQ5.push_back(int'(outPixel5));
      lastQ5.push_back(outLast5);
    end
    if (poolStart4 && !prevStart4) begin
      winQ4.push_back({w00_4, w01_4, w10_4, w11_4});
      if (prevFinish4) startOverFinish4++;
    end
    prevStart4  = poolStart4;
    prevFinish4 = poolFinish4;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic send4(input int v);
    int t = 0;
    inValid4 = 1'b1;
    inPixel4 = DW'(v);
    while (inReady4 !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL send4_timeout: pixel %0d not accepted, in_ready %b required 1", v, inReady4);
    end
    @(negedge clk);
    inValid4 = 1'b0;
  endtask

  task automatic send5(input int v);
    int t = 0;
    inValid5 = 1'b1;
    inPixel5 = DW'(v);
    while (inReady5 !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL send5_timeout: pixel %0d not accepted, in_ready %b required 1", v, inReady5);
    end
    @(negedge clk);
    inValid5 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    inValid4 = 1'b0; inPixel4 = '0; outReady4 = 1'b1;
    inValid5 = 1'b0; inPixel5 = '0;
    repeat (3) @(negedge clk);
    vectors++; if (inReady4 !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_in_ready: got %b expected 0", inReady4); end
    vectors++; if (poolStart4 !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_pool_start: got %b expected 0", poolStart4); end
    vectors++; if (outValid4 !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_out_valid: got %b expected 0", outValid4); end
    vectors++; if (outLast4 !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_out_last: got %b expected 0", outLast4); end
    vectors++; if (outPixel4 !== '0) begin miscompares++; $display("[TB] FAIL rst_out_pixel: got %0d expected 0", outPixel4); end
    vectors++; if (poolErr4 !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_pool_err: got %b expected 0", poolErr4); end
    vectors++; if ({w00_4, w01_4, w10_4, w11_4} !== 64'd0) begin miscompares++; $display("[TB] FAIL rst_window: got %h expected 0", {w00_4, w01_4, w10_4, w11_4}); end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (inReady4 !== 1'b1) begin miscompares++; $display("[TB] FAIL rel_in_ready4: got %b expected 1", inReady4); end
    vectors++; if (inReady5 !== 1'b1) begin miscompares++; $display("[TB] FAIL rel_in_ready5: got %b expected 1", inReady5); end
  endtask

  task automatic wait_out4(input int n);
    int t = 0;
    while (outQ4.size() < n && t < 500) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (outQ4.size() != n) begin
      miscompares++;
      $display("[TB] FAIL out4_count: got %0d results expected %0d", outQ4.size(), n);
    end
  endtask

  task automatic check_frame4(input int base, input string tag);
    int expPix[4];
    bit expLast[4];
    // Window averages of {0,1,4,5},{2,3,6,7},{8,9,12,13},{10,11,14,15} plus base
    expPix  = '{base + 2, base + 4, base + 10, base + 12};
    expLast = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (outQ4[i] !== expPix[i] || lastQ4[i] !== expLast[i]) begin
        miscompares++;
        $display("[TB] FAIL %s_out%0d: got pixel %0d last %b expected pixel %0d last %b",
                 tag, i, outQ4[i], lastQ4[i], expPix[i], expLast[i]);
      end
    end
  endtask

  task automatic test_ideal();
    logic [63:0] expWin[4];
    poolDelay4 = 0;
    outQ4.delete(); lastQ4.delete(); winQ4.delete();
    for (int v = 0; v < 16; v++) send4(v);
    wait_out4(4);
    check_frame4(0, "ideal");
    expWin = '{{16'd0, 16'd1, 16'd4, 16'd5}, {16'd2, 16'd3, 16'd6, 16'd7},
               {16'd8, 16'd9, 16'd12, 16'd13}, {16'd10, 16'd11, 16'd14, 16'd15}};
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (winQ4[i] !== expWin[i]) begin
        miscompares++;
        $display("[TB] FAIL ideal_win%0d: got %h expected %h", i, winQ4[i], expWin[i]);
      end
    end
  endtask

  task automatic test_delayed_finish();
    int startCycles = 0;
    int winBad = 0;
    int readyBad = 0;
    int t = 0;
    poolDelay4 = 5;
    outQ4.delete(); lastQ4.delete();
    for (int v = 100; v < 106; v++) send4(v);
    while (!outValid4 && t < 40) begin
      if (poolStart4) begin
        startCycles++;
        if ({w00_4, w01_4, w10_4, w11_4} !== {16'd100, 16'd101, 16'd104, 16'd105}) winBad++;
      end
      if (inReady4 !== 1'b0) readyBad++;
      @(negedge clk);
      t++;
    end
    // finish rises 5 edges after start; start drops on the edge after that
    vectors++; if (startCycles !== 6) begin miscompares++; $display("[TB] FAIL delay_start_len: got %0d expected 6", startCycles); end
    vectors++; if (winBad !== 0) begin miscompares++; $display("[TB] FAIL delay_win_stable: got %0d bad cycles expected 0", winBad); end
    vectors++; if (readyBad !== 0) begin miscompares++; $display("[TB] FAIL delay_in_ready: got %0d ready cycles expected 0", readyBad); end
    for (int v = 106; v < 116; v++) send4(v);
    wait_out4(4);
    check_frame4(100, "delay");
    vectors++; if (startOverFinish4 !== 0) begin miscompares++; $display("[TB] FAIL four_phase: got %0d starts over finish expected 0", startOverFinish4); end
  endtask

  task automatic test_backpressure();
    int holdBad = 0;
    int t = 0;
    poolDelay4 = 0;
    outQ4.delete(); lastQ4.delete();
    @(posedge clk); #1 outReady4 = 1'b0;
    @(negedge clk);
    for (int v = 200; v < 206; v++) send4(v);
    while (!outValid4 && t < 20) begin @(negedge clk); t++; end
    for (int i = 0; i < 10; i++) begin
      if (outValid4 !== 1'b1 || outPixel4 !== 16'sd202 || poolStart4 !== 1'b0 || inReady4 !== 1'b0) holdBad++;
      @(negedge clk);
    end
    vectors++; if (holdBad !== 0) begin miscompares++; $display("[TB] FAIL bp_hold: got %0d bad cycles expected 0", holdBad); end
    vectors++; if (outQ4.size() !== 0) begin miscompares++; $display("[TB] FAIL bp_no_transfer: got %0d results expected 0", outQ4.size()); end
    @(posedge clk); #1 outReady4 = 1'b1;
    @(negedge clk);
    for (int v = 206; v < 216; v++) send4(v);
    wait_out4(4);
    check_frame4(200, "bp");
  endtask

  task automatic test_odd_size();
    int expPix[8];
    bit expLast[8];
    int t = 0;
    outQ5.delete(); lastQ5.delete();
    for (int v = 0; v < 25; v++) send5(v);
    for (int v = 100; v < 125; v++) send5(v);
    while (outQ5.size() < 8 && t < 100) begin @(negedge clk); t++; end
    vectors++; if (outQ5.size() !== 8) begin miscompares++; $display("[TB] FAIL odd_count: got %0d expected 8", outQ5.size()); end
    // {0,1,5,6}=3 {2,3,7,8}=5 {10,11,15,16}=13 {12,13,17,18}=15, second frame +100
    expPix  = '{3, 5, 13, 15, 103, 105, 113, 115};
    expLast = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (outQ5[i] !== expPix[i] || lastQ5[i] !== expLast[i]) begin
        miscompares++;
        $display("[TB] FAIL odd_out%0d: got pixel %0d last %b expected pixel %0d last %b",
                 i, outQ5[i], lastQ5[i], expPix[i], expLast[i]);
      end
    end
  endtask

  task automatic test_reset_midop();
    poolDelay4 = 1000;
    outQ4.delete(); lastQ4.delete();
    for (int v = 300; v < 306; v++) send4(v);
    vectors++; if (poolStart4 !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_in_req: got start %b expected 1", poolStart4); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (poolStart4 !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_start_drop: got %b expected 0", poolStart4); end
    vectors++; if (outValid4 !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_out_valid: got %b expected 0", outValid4); end
    vectors++; if (inReady4 !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_in_ready: got %b expected 0", inReady4); end
    @(negedge clk);
    poolDelay4 = 0;
    rst_n = 1'b1;
    @(negedge clk);
    for (int v = 0; v < 16; v++) send4(v);
    wait_out4(4);
    check_frame4(0, "midrst");
  endtask

`ifdef POOL_FEEDER_TIMEOUT_EN
  task automatic test_timeout();
    int startCycles = 0;
    int t = 0;
    poolDelay4 = 1000;
    outQ4.delete(); lastQ4.delete();
    @(posedge clk); #1 outReady4 = 1'b0;
    @(negedge clk);
    for (int v = 400; v < 406; v++) send4(v);
    while (poolStart4 && t < 50) begin startCycles++; @(negedge clk); t++; end
    vectors++; if (startCycles !== 8) begin miscompares++; $display("[TB] FAIL to_start_len: got %0d expected 8", startCycles); end
    vectors++; if (poolErr4 !== 1'b1) begin miscompares++; $display("[TB] FAIL to_err: got %b expected 1", poolErr4); end
    vectors++; if (outValid4 !== 1'b1 || outPixel4 !== '0) begin miscompares++; $display("[TB] FAIL to_out: got valid %b pixel %0d expected valid 1 pixel 0", outValid4, outPixel4); end
    @(posedge clk); #1 outReady4 = 1'b1;
    repeat (5) @(negedge clk);
    vectors++; if (poolErr4 !== 1'b1) begin miscompares++; $display("[TB] FAIL to_err_sticky: got %b expected 1", poolErr4); end
  endtask
`endif

  initial begin
    test_reset();
    test_ideal();
    test_delayed_finish();
    test_backpressure();
    test_odd_size();
    test_reset_midop();
`ifdef POOL_FEEDER_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
